// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared VGA types and constants. Holds the background scroll
//                state type and the default background width used by both the
//                scroll controller and the background renderer.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_pkg;

    // Background width in ROM pixels; scroll_x always stays below this.
    localparam int c_scroll_w_default = 320;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        PAUSE    = 3'd2,
        STOPPING = 3'd3,
        HALT     = 3'd4
    } bg_state_t;

    // Modular advance of a 9-bit offset by a small step. The sum is formed
    // 10 bits wide so an offset near the top plus the step cannot overflow
    // before the wrap compare.
    function automatic logic [8:0] wrap_add(
        input logic [8:0] x,
        input logic [2:0] step,
        input logic [9:0] width
    );
        logic [9:0] w_sum;
        logic [9:0] w_diff;
        w_sum  = {1'b0, x} + {7'd0, step};
        w_diff = w_sum - width;
        if (w_sum < width)
            return w_sum[8:0];
        else
            return w_diff[8:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_if
//  Description : VGA timing bundle. The timing generator drives it through
//                the 'out' modport; monitors observe it through 'in'.
//                Ports : vblnk - vertical blanking, high during blanking.
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_if;
    logic vblnk;

    modport out (output vblnk);
    modport in  (input  vblnk);
endinterface
`default_nettype wire

// File: rtl/frame_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : frame_tick_gen
//  Description : Frame-boundary detector. Flags the cycle in which vblnk is
//                high after having been low the previous cycle.
//                Ports : clk   - pixel clock
//                        rst   - synchronous active-high reset
//                        vblnk - vertical blanking from the timing monitor
//                        tick  - combinational boundary flag (cycle n)
//  Revision    : 1.0  initial release
// ============================================================================
module frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic vblnk,
    output logic tick
);

    logic r_vblnk_q;
    // The history is cleared by reset, so a vblnk that is already high when
    // reset releases would look like a rising edge. r_armed suppresses
    // detection until vblnk has been observed low at least once.
    logic r_armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vblnk_q <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_vblnk_q <= vblnk;
            if (!vblnk)
                r_armed <= 1'b1;
        end
    end

    assign tick = vblnk & ~r_vblnk_q & r_armed;

endmodule
`default_nettype wire

// File: rtl/bg_scroll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bg_scroll_ctrl
//  Description : Background scroll controller. Commands are latched as
//                pending flags and acted on once per frame; every output
//                changes only in the frame_tick cycle so the renderer never
//                sees a mid-frame update.
//                Ports : clk, rst             - clock, sync active-high reset
//                        vin                  - timing monitor (vblnk only)
//                        start/stop/pause_tgl - single-cycle command pulses
//                        scroll_x             - offset 0..SCROLL_W-1
//                        speed                - step in pixels/frame
//                        frame_tick           - one pulse per frame
//                        state                - current FSM state
//  Revision    : 1.0  initial release
// ============================================================================
module bg_scroll_ctrl
    import vga_pkg::*;
#(
    parameter int SCROLL_W        = c_scroll_w_default,
    parameter int SPEED_INIT      = 1,
    parameter int SPEED_MAX       = 4,
    parameter int SPEED_UP_FRAMES = 600
) (
    input  logic       clk,
    input  logic       rst,
    vga_if.in          vin,
    input  logic       start,
    input  logic       stop,
    input  logic       pause_tgl,
    output logic [8:0] scroll_x,
    output logic [2:0] speed,
    output logic       frame_tick,
    output bg_state_t  state
);

    localparam int c_cnt_w = (SPEED_UP_FRAMES > 1) ? $clog2(SPEED_UP_FRAMES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(SPEED_UP_FRAMES - 1);
    localparam logic [9:0]         c_scroll_w  = 10'(SCROLL_W);
    localparam logic [2:0]         c_speed_ini = 3'(SPEED_INIT);
    localparam logic [2:0]         c_speed_max = 3'(SPEED_MAX);

    bg_state_t          r_state, w_state_nxt;
    logic [8:0]         r_scroll, w_scroll_nxt;
    logic [2:0]         r_speed, w_speed_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic               r_tick;
    logic               r_pend_start, r_pend_stop, r_pend_pause;

    logic               w_tick;
    logic               w_pend_start, w_pend_stop, w_pend_pause;
    logic               w_start_go;
    logic [8:0]         w_adv;

    frame_tick_gen u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .vblnk (vin.vblnk),
        .tick  (w_tick)
    );

    // A pulse arriving in the boundary cycle itself is folded in and
    // consumed with the rest rather than carried into the next frame.
    assign w_pend_start = r_pend_start | start;
    assign w_pend_stop  = r_pend_stop  | stop;
    assign w_pend_pause = r_pend_pause | pause_tgl;
    // Stop outranks start when both are waiting.
    assign w_start_go   = w_pend_start & ~w_pend_stop;
    assign w_adv        = wrap_add(r_scroll, r_speed, c_scroll_w);

    always_comb begin
        w_state_nxt  = r_state;
        w_scroll_nxt = r_scroll;
        w_speed_nxt  = r_speed;
        w_cnt_nxt    = r_cnt;
        if (w_tick) begin
            case (r_state)
                IDLE, HALT: begin
                    if (w_start_go) begin
                        w_state_nxt  = RUN;
                        w_scroll_nxt = 9'd0;
                        w_speed_nxt  = c_speed_ini;
                        w_cnt_nxt    = '0;
                    end
                end
                RUN: begin
                    if (w_pend_stop) begin
                        // The stop frame is already the first deceleration step.
                        w_state_nxt  = STOPPING;
                        w_scroll_nxt = w_adv;
                        w_speed_nxt  = (r_speed != 3'd0) ? r_speed - 3'd1 : 3'd0;
                    end else if (w_pend_pause) begin
                        // Freeze immediately: no advance on the pausing frame.
                        w_state_nxt = PAUSE;
                    end else begin
                        w_scroll_nxt = w_adv;
                        if (r_cnt == c_cnt_last) begin
                            w_cnt_nxt = '0;
                            if (r_speed < c_speed_max)
                                w_speed_nxt = r_speed + 3'd1;
                        end else begin
                            w_cnt_nxt = r_cnt + c_cnt_w'(1);
                        end
                    end
                end
                PAUSE: begin
                    if (w_pend_stop)
                        w_state_nxt = HALT;
                    else if (w_pend_pause)
                        w_state_nxt = RUN;
                end
                STOPPING: begin
                    // Speed reached zero on the previous frame; settle now.
                    if (r_speed == 3'd0) begin
                        w_state_nxt = HALT;
                    end else begin
                        w_scroll_nxt = w_adv;
                        w_speed_nxt  = r_speed - 3'd1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_scroll     <= 9'd0;
            r_speed      <= c_speed_ini;
            r_cnt        <= '0;
            r_tick       <= 1'b0;
            r_pend_start <= 1'b0;
            r_pend_stop  <= 1'b0;
            r_pend_pause <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_scroll     <= w_scroll_nxt;
            r_speed      <= w_speed_nxt;
            r_cnt        <= w_cnt_nxt;
            r_tick       <= w_tick;
            r_pend_start <= w_pend_start & ~w_tick;
            r_pend_stop  <= w_pend_stop  & ~w_tick;
            r_pend_pause <= w_pend_pause & ~w_tick;
        end
    end

    assign scroll_x   = r_scroll;
    assign speed      = r_speed;
    assign frame_tick = r_tick;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_bg_scroll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bg_scroll_ctrl
//  Description : Self-checking bench for bg_scroll_ctrl. Three instances run
//                side by side (speed-up period 600, 4 and 5 frames) against a
//                frame-level reference model, with directed scenarios
//                followed by randomized command traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bg_scroll_ctrl;
    import vga_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_if vin ();

    logic [2:0] cmd_start, cmd_stop, cmd_pause;
    bg_state_t  st [3];
    logic [8:0] sx [3];
    logic [2:0] sp [3];
    logic       ft [3];

    bg_scroll_ctrl #(.SPEED_UP_FRAMES(600)) u_dut0 (
        .clk(clk), .rst(rst), .vin(vin), .start(cmd_start[0]), .stop(cmd_stop[0]),
        .pause_tgl(cmd_pause[0]), .scroll_x(sx[0]), .speed(sp[0]),
        .frame_tick(ft[0]), .state(st[0]));
    bg_scroll_ctrl #(.SPEED_UP_FRAMES(4)) u_dut1 (
        .clk(clk), .rst(rst), .vin(vin), .start(cmd_start[1]), .stop(cmd_stop[1]),
        .pause_tgl(cmd_pause[1]), .scroll_x(sx[1]), .speed(sp[1]),
        .frame_tick(ft[1]), .state(st[1]));
    bg_scroll_ctrl #(.SPEED_UP_FRAMES(5)) u_dut2 (
        .clk(clk), .rst(rst), .vin(vin), .start(cmd_start[2]), .stop(cmd_stop[2]),
        .pause_tgl(cmd_pause[2]), .scroll_x(sx[2]), .speed(sp[2]),
        .frame_tick(ft[2]), .state(st[2]));

    int n_vec;
    int n_err;

    // Reference model: one frame of behaviour per call.
    bg_state_t m_st  [3];
    int        m_x   [3];
    int        m_spd [3];
    int        m_run [3];
    bit        m_pst [3];
    bit        m_psp [3];
    bit        m_ppa [3];

    function automatic int suf(input int i);
        return (i == 0) ? 600 : (i == 1) ? 4 : 5;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_st[i] = IDLE; m_x[i] = 0; m_spd[i] = 1; m_run[i] = 0;
            m_pst[i] = 0; m_psp[i] = 0; m_ppa[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        bit go_start;
        go_start = m_pst[i] && !m_psp[i];
        case (m_st[i])
            IDLE, HALT:
                if (go_start) begin
                    m_st[i] = RUN; m_x[i] = 0; m_spd[i] = 1; m_run[i] = 0;
                end
            RUN:
                if (m_psp[i]) begin
                    m_st[i]  = STOPPING;
                    m_x[i]   = (m_x[i] + m_spd[i]) % 320;
                    m_spd[i] = (m_spd[i] > 0) ? m_spd[i] - 1 : 0;
                end else if (m_ppa[i]) begin
                    m_st[i] = PAUSE;
                end else begin
                    m_x[i]   = (m_x[i] + m_spd[i]) % 320;
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == suf(i)) begin
                        m_run[i] = 0;
                        if (m_spd[i] < 4) m_spd[i] = m_spd[i] + 1;
                    end
                end
            PAUSE:
                if (m_psp[i])      m_st[i] = HALT;
                else if (m_ppa[i]) m_st[i] = RUN;
            STOPPING:
                if (m_spd[i] == 0) begin
                    m_st[i] = HALT;
                end else begin
                    m_x[i]   = (m_x[i] + m_spd[i]) % 320;
                    m_spd[i] = m_spd[i] - 1;
                end
            default: m_st[i] = IDLE;
        endcase
        m_pst[i] = 0; m_psp[i] = 0; m_ppa[i] = 0;
    endtask

    task automatic check(input string tag, input int i, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d: observed %0d expected %0d", tag, i, got, exp);
        end
    endtask

    task automatic check_model(input int i);
        check("state", i, 32'(st[i]), 32'(m_st[i]));
        check("scroll_x", i, 32'(sx[i]), m_x[i]);
        check("speed", i, 32'(sp[i]), m_spd[i]);
    endtask

    // One-cycle command pulses; caller sits #1 after a rising edge.
    task automatic pulse(input logic [2:0] s, input logic [2:0] p, input logic [2:0] t);
        cmd_start = s; cmd_stop = p; cmd_pause = t;
        for (int i = 0; i < 3; i++) begin
            if (s[i]) m_pst[i] = 1;
            if (p[i]) m_psp[i] = 1;
            if (t[i]) m_ppa[i] = 1;
        end
        @(posedge clk); #1;
        cmd_start = '0; cmd_stop = '0; cmd_pause = '0;
        @(posedge clk); #1;
    endtask

    // vblnk low -> rise; tick expected one cycle after the rise, one wide.
    task automatic do_frame();
        repeat (2) begin @(posedge clk); #1; end
        vin.vblnk = 1'b1;
        for (int i = 0; i < 3; i++) check("tick_early", i, 32'(ft[i]), 0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            model_step(i);
            check("tick", i, 32'(ft[i]), 1);
            check_model(i);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) check("tick_width", i, 32'(ft[i]), 0);
        vin.vblnk = 1'b0;
    endtask

    task automatic check_reset_state();
        for (int i = 0; i < 3; i++) begin
            check("rst_state", i, 32'(st[i]), 32'(IDLE));
            check("rst_scroll", i, 32'(sx[i]), 0);
            check("rst_speed", i, 32'(sp[i]), 1);
            check("rst_tick", i, 32'(ft[i]), 0);
        end
    endtask

    initial begin
        int x34;
        logic [31:0] m;
        n_vec = 0; n_err = 0;
        rst = 1'b1; vin.vblnk = 1'b0;
        cmd_start = '0; cmd_stop = '0; cmd_pause = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_state();

        // Tick timing over three idle frames.
        repeat (3) do_frame();

        // Start everything; tick 0 loads, no advance.
        pulse(3'b111, 3'b000, 3'b000);
        do_frame();

        x34 = 0;
        for (int f = 1; f <= 340; f++) begin
            if (f == 21) pulse(3'b000, 3'b010, 3'b000);
            if (f == 26) pulse(3'b010, 3'b000, 3'b000);
            if (f == 35) pulse(3'b010, 3'b010, 3'b000);
            if (f == 331) begin
                pulse(3'b000, 3'b000, 3'b001);
                pulse(3'b000, 3'b000, 3'b001);
            end
            if (f == 337) pulse(3'b000, 3'b000, 3'b001);
            do_frame();

            // Scroll and wrap at step 1, then pause/resume.
            if (f <= 330) check("dut0_speed_flat", 0, 32'(sp[0]), 1);
            if (f == 1)   check("dut0_x_t1", 0, 32'(sx[0]), 1);
            if (f == 319) check("dut0_x_t319", 0, 32'(sx[0]), 319);
            if (f == 320) check("dut0_x_wrap", 0, 32'(sx[0]), 0);
            if (f == 330) check("dut0_x_t330", 0, 32'(sx[0]), 10);
            if (f >= 331 && f <= 336) begin
                check("pause_state", 0, 32'(st[0]), 32'(PAUSE));
                check("pause_x", 0, 32'(sx[0]), 10);
            end
            if (f == 337) begin
                check("resume_state", 0, 32'(st[0]), 32'(RUN));
                check("resume_x", 0, 32'(sx[0]), 10);
                check("resume_speed", 0, 32'(sp[0]), 1);
            end
            if (f == 338) check("resume_adv", 0, 32'(sx[0]), 11);

            // Speed ramp with a 4-frame period, then simultaneous start+stop.
            if (f <= 20)
                check("ramp_speed", 1, 32'(sp[1]),
                      (f < 4) ? 1 : (f < 8) ? 2 : (f < 12) ? 3 : 4);
            if (f == 34) begin
                check("pre_stop_speed", 1, 32'(sp[1]), 3);
                x34 = int'(sx[1]);
            end
            if (f == 35) begin
                check("stop_state", 1, 32'(st[1]), 32'(STOPPING));
                check("stop_speed2", 1, 32'(sp[1]), 2);
            end
            if (f == 36) check("stop_speed1", 1, 32'(sp[1]), 1);
            if (f == 37) begin
                check("stop_speed0", 1, 32'(sp[1]), 0);
                check("stop_dist", 1, 32'(sx[1]), (x34 + 6) % 320);
            end
            if (f == 38) check("halt_state", 1, 32'(st[1]), 32'(HALT));

            // Wrap at step 4 from 318 (5-frame period).
            if (f == 15) check("dut2_speed4", 2, 32'(sp[2]), 4);
            if (f == 87) check("dut2_x318", 2, 32'(sx[2]), 318);
            if (f == 88) check("dut2_wrap4", 2, 32'(sx[2]), 2);
        end

        // Into STOPPING, then reset mid-line while vblnk is high.
        pulse(3'b000, 3'b111, 3'b000);
        do_frame();
        check("pre_rst_stopping", 0, 32'(st[0]), 32'(STOPPING));
        @(posedge clk); #1;
        vin.vblnk = 1'b1;
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        model_reset();
        check_reset_state();
        repeat (5) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) check("no_tick_high", i, 32'(ft[i]), 0);
        end
        vin.vblnk = 1'b0;
        do_frame();

        // Randomized command traffic.
        for (int r = 0; r < 150; r++) begin
            for (int k = 0; k < 2; k++) begin
                m = $urandom;
                pulse(m[2:0] & m[5:3], m[8:6] & m[11:9] & m[14:12], m[17:15] & m[20:18]);
            end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            do_frame();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
